// File: rtl/tmds_pll_ctrl_if.sv
// Control/status bundle between the TMDS PLL bring-up controller and the PLL/system side.
// master = controller, slave = PLL primitive plus whoever issues restart and consumes status.
interface tmds_pll_ctrl_if;
  logic       restart;
  logic       pll_lock;
  logic       pll_reset;
  logic [5:0] icpsel;
  logic [2:0] lpfres;
  logic [1:0] lpfcap;
  logic       pll_ready;
  logic       fail;
  logic [3:0] attempt;

  modport master (
    input  restart,
    input  pll_lock,
    output pll_reset,
    output icpsel,
    output lpfres,
    output lpfcap,
    output pll_ready,
    output fail,
    output attempt
  );

  modport slave (
    output restart,
    output pll_lock,
    input  pll_reset,
    input  icpsel,
    input  lpfres,
    input  lpfcap,
    input  pll_ready,
    input  fail,
    input  attempt
  );
endinterface

// File: rtl/tmds_pll_ctrl.sv
// PLL bring-up controller: reset pulse, bounded lock wait, stability qualification, limited retries.
// Define TMDS_PLL_SWEEP_EN to step the charge-pump/loop-filter settings table on every retry.
module tmds_pll_ctrl #(
  parameter int RST_CYCLES   = 64,
  parameter int LOCK_TIMEOUT = 50000,
  parameter int LOCK_STABLE  = 1024,
  parameter int MAX_RETRY    = 7
) (
  input  logic            clk,
  input  logic            rst_n,
  tmds_pll_ctrl_if.master bus
);

  localparam int RW = $clog2(RST_CYCLES) + 1;
  localparam int TW = $clog2(LOCK_TIMEOUT) + 1;
  localparam int SW = $clog2(LOCK_STABLE) + 1;

  localparam logic [RW-1:0] RST_LAST  = RW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(LOCK_TIMEOUT - 1);
  localparam logic [SW-1:0] STAB_LAST = SW'(LOCK_STABLE - 1);
  localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    ST_RST,
    ST_WAIT_LOCK,
    ST_STABLE,
    ST_LOCKED,
    ST_FAIL
  } state_t;

  state_t          state_q, state_d;
  logic            lock_meta_q, lock_s_q;
  logic [RW-1:0]   rst_cnt_q, rst_cnt_d;
  logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [SW-1:0]   stab_cnt_q, stab_cnt_d;
  logic [3:0]      attempt_q, attempt_d;
  logic            pll_reset_q, pll_reset_d;
  logic            pll_ready_q, pll_ready_d;
  logic            fail_q, fail_d;
  logic            retry;
  logic            tmo_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
    end else begin
      lock_meta_q <= bus.pll_lock;
      lock_s_q    <= lock_meta_q;
    end
  end

  // The timeout budget covers the whole attempt (WAIT_LOCK and STABLE) so a chattering lock cannot stall it.
  assign tmo_hit = (tmo_cnt_q >= TMO_LAST);

  always_comb begin
    state_d    = state_q;
    rst_cnt_d  = rst_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    stab_cnt_d = stab_cnt_q;
    attempt_d  = attempt_q;
    retry      = 1'b0;

    unique case (state_q)
      ST_RST: begin
        if (rst_cnt_q == RST_LAST) begin
          state_d   = ST_WAIT_LOCK;
          rst_cnt_d = '0;
          tmo_cnt_d = '0;
          // An attempt is counted when it starts, i.e. when the PLL is released from reset.
          attempt_d = (attempt_q == 4'hF) ? attempt_q : attempt_q + 4'd1;
        end else begin
          rst_cnt_d = rst_cnt_q + RW'(1);
        end
      end
      ST_WAIT_LOCK: begin
        if (tmo_hit) begin
          retry = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
          if (lock_s_q) begin
            state_d    = ST_STABLE;
            stab_cnt_d = SW'(1);
          end
        end
      end
      ST_STABLE: begin
        if (tmo_hit) begin
          retry = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
          if (!lock_s_q) begin
            state_d = ST_WAIT_LOCK;
          end else if (stab_cnt_q >= STAB_LAST) begin
            state_d = ST_LOCKED;
          end else begin
            stab_cnt_d = stab_cnt_q + SW'(1);
          end
        end
      end
      ST_LOCKED: begin
        if (!lock_s_q) begin
          retry = 1'b1;
        end
      end
      ST_FAIL: begin
        state_d = ST_FAIL;
      end
      default: begin
        state_d   = ST_RST;
        rst_cnt_d = '0;
      end
    endcase

    if (retry) begin
      if (attempt_q >= RETRY_MAX) begin
        state_d = ST_FAIL;
      end else begin
        state_d   = ST_RST;
        rst_cnt_d = '0;
      end
    end

    if (bus.restart) begin
      state_d    = ST_RST;
      rst_cnt_d  = '0;
      tmo_cnt_d  = '0;
      stab_cnt_d = '0;
      attempt_d  = '0;
    end

    pll_reset_d = (state_d == ST_RST) || (state_d == ST_FAIL);
    pll_ready_d = (state_q == ST_LOCKED) && (state_d == ST_LOCKED);
    fail_d      = (state_d == ST_FAIL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RST;
      rst_cnt_q   <= '0;
      tmo_cnt_q   <= '0;
      stab_cnt_q  <= '0;
      attempt_q   <= '0;
      pll_reset_q <= 1'b1;
      pll_ready_q <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      stab_cnt_q  <= stab_cnt_d;
      attempt_q   <= attempt_d;
      pll_reset_q <= pll_reset_d;
      pll_ready_q <= pll_ready_d;
      fail_q      <= fail_d;
    end
  end

  assign bus.pll_reset = pll_reset_q;
  assign bus.pll_ready = pll_ready_q;
  assign bus.fail      = fail_q;
  assign bus.attempt   = attempt_q;

`ifdef TMDS_PLL_SWEEP_EN
  localparam logic [10:0] SET_IDX0 = {6'd16, 3'd2, 2'd0};

  logic [1:0]  idx_q, idx_d;
  logic [10:0] set_q, set_d;
  logic        load_rst;

  function automatic logic [10:0] settings_lut(input logic [1:0] idx);
    logic [10:0] s;
    case (idx)
      2'd0:    s = {6'd16, 3'd2, 2'd0};
      2'd1:    s = {6'd24, 3'd3, 2'd0};
      2'd2:    s = {6'd32, 3'd4, 2'd1};
      default: s = {6'd8,  3'd1, 2'd0};
    endcase
    return s;
  endfunction

  // Settings move only on entry to RST, so the PLL never sees them change while running.
  always_comb begin
    idx_d    = idx_q;
    set_d    = set_q;
    load_rst = (state_d == ST_RST) && ((state_q != ST_RST) || bus.restart);
    if (bus.restart) begin
      idx_d = 2'd0;
    end else if (retry && (state_d == ST_RST)) begin
      idx_d = idx_q + 2'd1;
    end
    if (load_rst) begin
      set_d = settings_lut(idx_d);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= 2'd0;
      set_q <= SET_IDX0;
    end else begin
      idx_q <= idx_d;
      set_q <= set_d;
    end
  end

  assign bus.icpsel = set_q[10:5];
  assign bus.lpfres = set_q[4:2];
  assign bus.lpfcap = set_q[1:0];
`else
  assign bus.icpsel = 6'd16;
  assign bus.lpfres = 3'd2;
  assign bus.lpfcap = 2'd0;
`endif

endmodule

// File: tb/tb_tmds_pll_ctrl.sv
// Directed bench for tmds_pll_ctrl with short timers; expected settings follow TMDS_PLL_SWEEP_EN.
module tb_tmds_pll_ctrl;

  localparam int RST_CYCLES   = 4;
  localparam int LOCK_TIMEOUT = 20;
  localparam int LOCK_STABLE  = 5;
  localparam int MAX_RETRY    = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  tmds_pll_ctrl_if bus();

  tmds_pll_ctrl #(
    .RST_CYCLES  (RST_CYCLES),
    .LOCK_TIMEOUT(LOCK_TIMEOUT),
    .LOCK_STABLE (LOCK_STABLE),
    .MAX_RETRY   (MAX_RETRY)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Expected {icpsel, lpfres, lpfcap} for the n-th settings step.
  function automatic logic [10:0] exp_set(input int n);
    int i;
    logic [10:0] s;
    i = n % 4;
`ifndef TMDS_PLL_SWEEP_EN
    i = 0;
`endif
    case (i)
      0:       s = {6'd16, 3'd2, 2'd0};
      1:       s = {6'd24, 3'd3, 2'd0};
      2:       s = {6'd32, 3'd4, 2'd1};
      default: s = {6'd8,  3'd1, 2'd0};
    endcase
    return s;
  endfunction

  function automatic logic [10:0] got_set();
    return {bus.icpsel, bus.lpfres, bus.lpfcap};
  endfunction

  // Edges until pll_reset reaches level; -1 if the bound expires.
  task automatic wait_reset(input logic level, output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (bus.pll_reset !== level && n < 200);
    if (bus.pll_reset !== level) n = -1;
  endtask

  task automatic wait_ready(input logic level, output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (bus.pll_ready !== level && n < 200);
    if (bus.pll_ready !== level) n = -1;
  endtask

  task automatic test_reset();
    int c;
    bus.restart  = 1'b0;
    bus.pll_lock = 1'b0;
    rst_n        = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.pll_reset !== 1'b1) begin errors++; $display("FAIL rst_pll_reset: got %b expected 1", bus.pll_reset); end
    checks++; if (bus.pll_ready !== 1'b0) begin errors++; $display("FAIL rst_pll_ready: got %b expected 0", bus.pll_ready); end
    checks++; if (bus.fail !== 1'b0) begin errors++; $display("FAIL rst_fail: got %b expected 0", bus.fail); end
    checks++; if (bus.attempt !== 4'd0) begin errors++; $display("FAIL rst_attempt: got %0d expected 0", bus.attempt); end
    checks++; if (got_set() !== exp_set(0)) begin errors++; $display("FAIL rst_settings: got %h expected %h", got_set(), exp_set(0)); end
    rst_n = 1'b1;
    wait_reset(1'b0, c);
    checks++; if (c !== RST_CYCLES) begin errors++; $display("FAIL rst_pulse_width: got %0d expected %0d", c, RST_CYCLES); end
    checks++; if (bus.attempt !== 4'd1) begin errors++; $display("FAIL rst_first_attempt: got %0d expected 1", bus.attempt); end
    $display("test_reset done: pulse=%0d attempt=%0d", c, bus.attempt);
  endtask

  task automatic test_lock();
    int c;
    repeat (10) begin @(posedge clk); #1; end
    bus.pll_lock = 1'b1;
    wait_ready(1'b1, c);
    checks++; if (c !== 2 + LOCK_STABLE + 1) begin errors++; $display("FAIL lock_latency: got %0d expected %0d", c, 2 + LOCK_STABLE + 1); end
    checks++; if (bus.attempt !== 4'd1) begin errors++; $display("FAIL lock_attempt: got %0d expected 1", bus.attempt); end
    checks++; if (got_set() !== exp_set(0)) begin errors++; $display("FAIL lock_settings: got %h expected %h", got_set(), exp_set(0)); end
    repeat (5) begin @(posedge clk); #1; end
    checks++; if ({bus.pll_ready, bus.pll_reset, bus.fail} !== 3'b100) begin errors++; $display("FAIL lock_hold: got ready/reset/fail=%b expected 100", {bus.pll_ready, bus.pll_reset, bus.fail}); end
    $display("test_lock done: ready after %0d cycles", c);
  endtask

  task automatic test_lock_loss();
    int c;
    bus.pll_lock = 1'b0;
    wait_ready(1'b0, c);
    checks++; if (c !== 3) begin errors++; $display("FAIL loss_ready_drop: got %0d expected 3", c); end
    checks++; if (bus.pll_reset !== 1'b1) begin errors++; $display("FAIL loss_pll_reset: got %b expected 1", bus.pll_reset); end
    wait_reset(1'b0, c);
    checks++; if (c !== RST_CYCLES) begin errors++; $display("FAIL loss_pulse_width: got %0d expected %0d", c, RST_CYCLES); end
    checks++; if (bus.attempt !== 4'd2) begin errors++; $display("FAIL loss_attempt: got %0d expected 2", bus.attempt); end
    checks++; if (got_set() !== exp_set(1)) begin errors++; $display("FAIL loss_settings: got %h expected %h", got_set(), exp_set(1)); end
    $display("test_lock_loss done: attempt=%0d", bus.attempt);
  endtask

  task automatic test_timeout_sweep();
    int c;
    bus.restart = 1'b1;
    @(posedge clk); #1;
    bus.restart = 1'b0;
    checks++; if (bus.attempt !== 4'd0) begin errors++; $display("FAIL sweep_restart_attempt: got %0d expected 0", bus.attempt); end
    checks++; if (bus.pll_reset !== 1'b1) begin errors++; $display("FAIL sweep_restart_reset: got %b expected 1", bus.pll_reset); end
    for (int n = 0; n < 3; n++) begin
      wait_reset(1'b0, c);
      checks++; if (c !== RST_CYCLES) begin errors++; $display("FAIL sweep_pulse_%0d: got %0d expected %0d", n, c, RST_CYCLES); end
      checks++; if (bus.attempt !== 4'(n + 1)) begin errors++; $display("FAIL sweep_attempt_%0d: got %0d expected %0d", n, bus.attempt, n + 1); end
      checks++; if (got_set() !== exp_set(n)) begin errors++; $display("FAIL sweep_settings_%0d: got %h expected %h", n, got_set(), exp_set(n)); end
      wait_reset(1'b1, c);
      checks++; if (c !== LOCK_TIMEOUT) begin errors++; $display("FAIL sweep_timeout_%0d: got %0d expected %0d", n, c, LOCK_TIMEOUT); end
      if (n < 2) begin
        checks++; if (got_set() !== exp_set(n + 1)) begin errors++; $display("FAIL sweep_next_settings_%0d: got %h expected %h", n, got_set(), exp_set(n + 1)); end
        checks++; if (bus.fail !== 1'b0) begin errors++; $display("FAIL sweep_early_fail_%0d: got %b expected 0", n, bus.fail); end
      end
      $display("test_timeout_sweep attempt %0d timed out, settings=%h", n + 1, got_set());
    end
    checks++; if (bus.fail !== 1'b1) begin errors++; $display("FAIL sweep_fail_flag: got %b expected 1", bus.fail); end
    checks++; if (bus.attempt !== 4'd3) begin errors++; $display("FAIL sweep_final_attempt: got %0d expected 3", bus.attempt); end
    repeat (10) begin @(posedge clk); #1; end
    checks++; if ({bus.pll_reset, bus.fail, bus.pll_ready} !== 3'b110) begin errors++; $display("FAIL sweep_fail_hold: got reset/fail/ready=%b expected 110", {bus.pll_reset, bus.fail, bus.pll_ready}); end
  endtask

  task automatic test_restart();
    int c;
    bus.restart = 1'b1;
    @(posedge clk); #1;
    bus.restart = 1'b0;
    checks++; if ({bus.fail, bus.attempt} !== 5'd0) begin errors++; $display("FAIL restart_clear: got fail=%b attempt=%0d expected 0/0", bus.fail, bus.attempt); end
    checks++; if (bus.pll_reset !== 1'b1) begin errors++; $display("FAIL restart_reset: got %b expected 1", bus.pll_reset); end
    checks++; if (got_set() !== exp_set(0)) begin errors++; $display("FAIL restart_settings: got %h expected %h", got_set(), exp_set(0)); end
    wait_reset(1'b0, c);
    checks++; if (c !== RST_CYCLES) begin errors++; $display("FAIL restart_pulse: got %0d expected %0d", c, RST_CYCLES); end
    checks++; if (bus.attempt !== 4'd1) begin errors++; $display("FAIL restart_attempt: got %0d expected 1", bus.attempt); end
    repeat (LOCK_TIMEOUT - 1) begin @(posedge clk); #1; end
    checks++; if (bus.pll_reset !== 1'b0) begin errors++; $display("FAIL restart_pre_timeout: got %b expected 0", bus.pll_reset); end
    bus.restart = 1'b1;
    @(posedge clk); #1;
    bus.restart = 1'b0;
    checks++; if ({bus.pll_reset, bus.attempt} !== 5'b1_0000) begin errors++; $display("FAIL restart_vs_timeout: got reset=%b attempt=%0d expected 1/0", bus.pll_reset, bus.attempt); end
    wait_reset(1'b0, c);
    checks++; if (c !== RST_CYCLES) begin errors++; $display("FAIL restart_vs_timeout_pulse: got %0d expected %0d", c, RST_CYCLES); end
    checks++; if (bus.attempt !== 4'd1) begin errors++; $display("FAIL restart_vs_timeout_attempt: got %0d expected 1", bus.attempt); end
    checks++; if (got_set() !== exp_set(0)) begin errors++; $display("FAIL restart_vs_timeout_settings: got %h expected %h", got_set(), exp_set(0)); end
    $display("test_restart done: attempt=%0d", bus.attempt);
  endtask

  task automatic test_stable_toggle();
    int c;
    int seen_ready;
    int rise_at;
    seen_ready = 0;
    rise_at    = -1;
    for (int j = 0; j < LOCK_TIMEOUT; j++) begin
      bus.pll_lock = (j % 4 != 3);
      @(posedge clk); #1;
      if (bus.pll_ready === 1'b1) seen_ready++;
      if (bus.pll_reset === 1'b1 && rise_at < 0) rise_at = j + 1;
    end
    bus.pll_lock = 1'b0;
    checks++; if (seen_ready !== 0) begin errors++; $display("FAIL toggle_ready_seen: got %0d cycles expected 0", seen_ready); end
    checks++; if (rise_at !== LOCK_TIMEOUT) begin errors++; $display("FAIL toggle_timeout_at: got %0d expected %0d", rise_at, LOCK_TIMEOUT); end
    wait_reset(1'b0, c);
    checks++; if (c !== RST_CYCLES) begin errors++; $display("FAIL toggle_pulse: got %0d expected %0d", c, RST_CYCLES); end
    checks++; if (bus.attempt !== 4'd2) begin errors++; $display("FAIL toggle_attempt: got %0d expected 2", bus.attempt); end
    checks++; if (got_set() !== exp_set(1)) begin errors++; $display("FAIL toggle_settings: got %h expected %h", got_set(), exp_set(1)); end
    $display("test_stable_toggle done: retry at cycle %0d", rise_at);
  endtask

  task automatic test_async_reset();
    int c;
    repeat (5) begin @(posedge clk); #1; end
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if ({bus.pll_reset, bus.pll_ready, bus.attempt} !== 6'b10_0000) begin errors++; $display("FAIL async_wait: got reset=%b ready=%b attempt=%0d expected 1/0/0", bus.pll_reset, bus.pll_ready, bus.attempt); end
    rst_n = 1'b1;
    wait_reset(1'b0, c);
    bus.pll_lock = 1'b1;
    wait_ready(1'b1, c);
    checks++; if (c !== 2 + LOCK_STABLE + 1) begin errors++; $display("FAIL async_relock: got %0d expected %0d", c, 2 + LOCK_STABLE + 1); end
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if ({bus.pll_reset, bus.pll_ready, bus.fail} !== 3'b100) begin errors++; $display("FAIL async_locked: got reset/ready/fail=%b expected 100", {bus.pll_reset, bus.pll_ready, bus.fail}); end
    bus.pll_lock = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    $display("test_async_reset done");
  endtask

  initial begin
    test_reset();
    test_lock();
    test_lock_loss();
    test_timeout_sweep();
    test_restart();
    test_stable_toggle();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
